// File: rtl/uart_tx_datapath.sv
// uart_tx_datapath: UART transmit baud counter, data-bit counter and serial frame shifter
module uart_tx_datapath #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DIV_WIDTH-1:0]  i_baud_divisor,
  input  logic                  i_parity_enable,
  input  logic                  i_parity,
  input  logic [DATA_WIDTH-1:0] i_tx_fifo_rd_data,
  input  logic                  i_tx_shift_reg_en,
  input  logic                  i_tx_shift_en,
  input  logic                  i_tx_baud_rate_reg_en,
  input  logic                  i_tx_bit_count_reg_en,
  output logic                  o_tx_baud_rate,
  output logic                  o_tx_bit_count,
  output logic                  o_tx
);
  localparam int FW = DATA_WIDTH + 4;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  logic [DIV_WIDTH-1:0] r_div_q;
  logic [DIV_WIDTH-1:0] r_baud_cnt;
  logic [CW-1:0]        r_bit_cnt;
  logic [FW-1:0]        r_frame;
  logic [DIV_WIDTH-1:0] w_eff;
  logic                 w_last;
  logic                 w_par_bit;
  assign w_eff          = (r_div_q == '0) ? DIV_WIDTH'(1) : r_div_q;
  assign w_last         = r_baud_cnt == w_eff - DIV_WIDTH'(1);
  assign w_par_bit      = i_parity_enable ? (i_parity ^ (^i_tx_fifo_rd_data)) : 1'b1;
  assign o_tx_baud_rate = i_tx_baud_rate_reg_en && w_last;
  assign o_tx_bit_count = r_bit_cnt >= CW'(DATA_WIDTH);
  assign o_tx           = r_frame[0];
  // Frame load (stop, parity, data, start, lead idle) with divisor latch; shifting fills ones from the top
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_frame <= '1;
      r_div_q <= '0;
    end else if (i_tx_shift_reg_en) begin
      r_frame <= {1'b1, w_par_bit, i_tx_fifo_rd_data, 2'b01};
      r_div_q <= i_baud_divisor;
    end else if (i_tx_shift_en) begin
      r_frame <= {1'b1, r_frame[FW-1:1]};
    end
  end
  // Baud period counter, cleared whenever the enable is low
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_baud_cnt <= '0;
    else r_baud_cnt <= (!i_tx_baud_rate_reg_en || w_last) ? '0 : r_baud_cnt + DIV_WIDTH'(1);
  end
  // Data-bit counter: load clears it, increments saturate at the data width
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_bit_cnt <= '0;
    else if (i_tx_shift_reg_en) r_bit_cnt <= '0;
    else if (i_tx_bit_count_reg_en && r_bit_cnt != CW'(DATA_WIDTH)) r_bit_cnt <= r_bit_cnt + CW'(1);
  end
endmodule

// File: tb/tb_uart_tx_datapath.sv
// tb_uart_tx_datapath: directed self-checking bench for the UART transmit datapath
module tb_uart_tx_datapath;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] div = '0;
  logic        pe = 1'b0;
  logic        par = 1'b0;
  logic [7:0]  data = '0;
  logic        load = 1'b0;
  logic        shift = 1'b0;
  logic        baud_en = 1'b0;
  logic        cnt_en = 1'b0;
  logic        tick;
  logic        bit_done;
  logic        tx;
  int          checks = 0;
  int          failures = 0;
  int          early;

  uart_tx_datapath #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .i_clock               (clk),
    .i_reset               (rst),
    .i_baud_divisor        (div),
    .i_parity_enable       (pe),
    .i_parity              (par),
    .i_tx_fifo_rd_data     (data),
    .i_tx_shift_reg_en     (load),
    .i_tx_shift_en         (shift),
    .i_tx_baud_rate_reg_en (baud_en),
    .i_tx_bit_count_reg_en (cnt_en),
    .o_tx_baud_rate        (tick),
    .o_tx_bit_count        (bit_done),
    .o_tx                  (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Loads a frame, scrambles the live config inputs, then plays the controller's shift/count schedule.
  // exp bit i is the line level during bit period i (lead idle, start, d0..d7, parity, stop).
  task automatic run_frame(input logic [7:0] d, input int dv, input logic p_en, input logic p_odd,
                           input logic [11:0] exp, input int stop_k);
    data = d; div = 16'(dv); pe = p_en; par = p_odd; load = 1'b1;
    baud_en = 1'b0; shift = 1'b0; cnt_en = 1'b0;
    @(negedge clk);
    load = 1'b0; data = ~d; div = 16'(dv + 3); pe = ~p_en; par = ~p_odd;
    for (int k = 0; k < 12 * dv; k++) begin
      if (k == stop_k) begin
        baud_en = 1'b0; shift = 1'b0; cnt_en = 1'b0;
        return;
      end
      baud_en = 1'b1;
      shift = (k % dv) == dv - 1;
      cnt_en = shift && (k / dv) >= 2 && (k / dv) <= 9;
      #1;
      check($sformatf("tx k=%0d", k), tx, exp[k / dv]);
      check($sformatf("tick k=%0d", k), tick, shift);
      check($sformatf("bitcnt k=%0d", k), bit_done, k >= 10 * dv);
      @(negedge clk);
    end
    baud_en = 1'b0; shift = 1'b0; cnt_en = 1'b0;
  endtask

  task automatic div_ticks(input logic [15:0] dv, input int n);
    int eff;
    eff = (dv == 0) ? 1 : int'(dv);
    div = dv; load = 1'b1;
    @(negedge clk);
    load = 1'b0; baud_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      #1;
      check($sformatf("div%0d tick k=%0d", dv, k), tick, (k % eff) == eff - 1);
      @(negedge clk);
    end
    baud_en = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_tx", tx, 1);
    check("rst_bitcnt", bit_done, 0);
    check("rst_tick", tick, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_frame(8'hA5, 4, 1'b0, 1'b0, 12'hE95, -1);
    run_frame(8'hA5, 2, 1'b1, 1'b0, 12'hA95, -1);
    run_frame(8'hA5, 2, 1'b1, 1'b1, 12'hE95, -1);
    run_frame(8'h07, 3, 1'b1, 1'b0, 12'hC1D, -1);

    div_ticks(16'd0, 4);
    div_ticks(16'd1, 4);
    div_ticks(16'd4, 9);

    div = 16'd4; load = 1'b1;
    @(negedge clk);
    load = 1'b0; baud_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    baud_en = 1'b0;
    #1 check("drop_tick", tick, 0);
    @(negedge clk);
    baud_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("restart tick k=%0d", k), tick, k == 3);
      @(negedge clk);
    end
    baud_en = 1'b0;

    div = 16'hFFFF; load = 1'b1;
    @(negedge clk);
    load = 1'b0; baud_en = 1'b1; early = 0;
    for (int k = 0; k < 65535; k++) begin
      #1;
      if (k < 65534 && tick) early++;
      if (k == 65534) check("ffff_first_tick", tick, 1);
      @(negedge clk);
    end
    check("ffff_early_ticks", early, 0);
    baud_en = 1'b0;
    @(negedge clk);

    run_frame(8'hA5, 16, 1'b0, 1'b0, 12'hE95, 5 * 16 + 5);
    #1 check("pre_rst_tx", tx, 0);
    #1 rst = 1'b1;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_bitcnt", bit_done, 0);
    check("midrst_tick", tick, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst_tx", tx, 1);
    baud_en = 1'b1;
    #1 check("postrst_tick_div0", tick, 1);
    baud_en = 1'b0;
    @(negedge clk);
    run_frame(8'h3C, 3, 1'b0, 1'b0, 12'hCF1, -1);

    data = 8'hFF; pe = 1'b0; div = 16'd2; load = 1'b1;
    @(negedge clk);
    load = 1'b0; shift = 1'b1;
    @(negedge clk);
    shift = 1'b0;
    #1 check("coll_pre_tx", tx, 0);
    data = 8'hFE; load = 1'b1; shift = 1'b1;
    @(negedge clk);
    load = 1'b0; shift = 1'b0;
    #1 check("coll_lead_tx", tx, 1);
    shift = 1'b1;
    @(negedge clk);
    shift = 1'b0;
    #1 check("coll_start_tx", tx, 0);
    shift = 1'b1;
    @(negedge clk);
    shift = 1'b0;
    #1 check("coll_d0_tx", tx, 0);

    cnt_en = 1'b1;
    repeat (7) @(negedge clk);
    #1 check("cnt7_bitcnt", bit_done, 0);
    @(negedge clk);
    #1 check("cnt8_bitcnt", bit_done, 1);
    repeat (9) @(negedge clk);
    #1 check("sat_bitcnt", bit_done, 1);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0; cnt_en = 1'b0;
    #1 check("coll_clear_bitcnt", bit_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
